pump_duty_scheduler: RTL and testbench



---
 rtl/pump_duty_scheduler.sv | 157 +++++++++++++++
 tb/tb_pump_duty_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pump_duty_scheduler.sv
// Two-pump lead/lag scheduler: turns level flags into pump run commands, rotating the lead
// on every normal stop and enforcing min-run, min-rest and start-stagger times in ticks.
module pump_duty_scheduler #(
   parameter int unsigned MIN_ON_TICKS  = 8,
   parameter int unsigned MIN_OFF_TICKS = 4,
   parameter int unsigned STAGGER_TICKS = 2,
   parameter int unsigned CNT_W         = 8
) (
   input  logic       CLK100MHZ,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       level_low,
   input  logic       level_mid,
   input  logic       level_high,
   input  logic [1:0] fault,
   output logic       pump1,
   output logic       pump2,
   output logic       lead_pump,
   output logic [1:0] state,
   output logic       alarm
);

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StLead = 2'b01,
      StBoth = 2'b10,
      StCool = 2'b11
   } state_e;

   localparam logic [CNT_W-1:0] MinOn   = CNT_W'(MIN_ON_TICKS);
   localparam logic [CNT_W-1:0] MinOff  = CNT_W'(MIN_OFF_TICKS);
   localparam logic [CNT_W-1:0] Stagger = CNT_W'(STAGGER_TICKS);

   state_e           state_q;
   logic [1:0]       demand, demand_q;
   logic [CNT_W-1:0] on_cnt, stag_cnt, off_cnt;
   logic             lead_bad, lag_bad, run_pump;

   // Saturating tick counter step.
   function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v, input logic en);
      return (en && (v != '1)) ? v + CNT_W'(1) : v;
   endfunction

   // No level flag asserted means the previous demand is held.
   always_comb begin
      demand = demand_q;
      if (level_high)     demand = 2'd0;
      else if (level_low) demand = 2'd2;
      else if (level_mid) demand = 2'd1;
   end

   assign lead_bad = fault[lead_pump];
   assign lag_bad  = fault[!lead_pump];
   assign run_pump = lead_bad ? ~lead_pump : lead_pump;
   assign state    = state_q;

   always_ff @(posedge CLK100MHZ or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         demand_q  <= 2'd0;
         on_cnt    <= '0;
         stag_cnt  <= '0;
         off_cnt   <= '0;
         pump1     <= 1'b0;
         pump2     <= 1'b0;
         lead_pump <= 1'b0;
         alarm     <= 1'b0;
      end else begin
         demand_q <= demand;
         alarm    <= (demand != 2'd0) && (fault == 2'b11);
         case (state_q)
            StIdle: begin
               pump1 <= 1'b0;
               pump2 <= 1'b0;
               if ((demand != 2'd0) && (fault != 2'b11)) begin
                  state_q   <= StLead;
                  lead_pump <= run_pump;
                  pump1     <= ~run_pump;
                  pump2     <= run_pump;
                  on_cnt    <= '0;
                  stag_cnt  <= '0;
               end
            end
            StLead: begin
               if (lead_bad) begin
                  // Faults preempt every timer: hand over or give up immediately.
                  if (!lag_bad) begin
                     lead_pump <= ~lead_pump;
                     pump1     <= lead_pump;
                     pump2     <= ~lead_pump;
                     on_cnt    <= '0;
                     stag_cnt  <= '0;
                  end else begin
                     state_q <= StCool;
                     pump1   <= 1'b0;
                     pump2   <= 1'b0;
                     off_cnt <= '0;
                  end
               end else if ((demand == 2'd2) && (stag_cnt >= Stagger) && !lag_bad) begin
                  state_q <= StBoth;
                  pump1   <= 1'b1;
                  pump2   <= 1'b1;
                  on_cnt  <= bump(on_cnt, tick);
               end else if ((demand == 2'd0) && (on_cnt >= MinOn)) begin
                  state_q   <= StCool;
                  lead_pump <= ~lead_pump;
                  pump1     <= 1'b0;
                  pump2     <= 1'b0;
                  off_cnt   <= '0;
               end else begin
                  pump1    <= ~lead_pump;
                  pump2    <= lead_pump;
                  on_cnt   <= bump(on_cnt, tick);
                  stag_cnt <= (demand == 2'd2) ? bump(stag_cnt, tick) : '0;
               end
            end
            StBoth: begin
               if (fault == 2'b11) begin
                  state_q <= StCool;
                  pump1   <= 1'b0;
                  pump2   <= 1'b0;
                  off_cnt <= '0;
               end else if (fault != 2'b00) begin
                  state_q   <= StLead;
                  lead_pump <= fault[0];
                  pump1     <= ~fault[0];
                  pump2     <= fault[0];
                  on_cnt    <= bump(on_cnt, tick);
                  stag_cnt  <= '0;
               end else if ((demand == 2'd0) && (on_cnt >= MinOn)) begin
                  state_q   <= StCool;
                  lead_pump <= ~lead_pump;
                  pump1     <= 1'b0;
                  pump2     <= 1'b0;
                  off_cnt   <= '0;
               end else if (demand != 2'd2) begin
                  state_q  <= StLead;
                  pump1    <= ~lead_pump;
                  pump2    <= lead_pump;
                  on_cnt   <= bump(on_cnt, tick);
                  stag_cnt <= '0;
               end else begin
                  on_cnt <= bump(on_cnt, tick);
               end
            end
            StCool: begin
               pump1 <= 1'b0;
               pump2 <= 1'b0;
               if (off_cnt >= MinOff) state_q <= StIdle;
               else                   off_cnt <= bump(off_cnt, tick);
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_pump_duty_scheduler.sv
// Bench for pump_duty_scheduler: hand-derived vector table, multi-cycle corner sequences and
// randomized stimulus against a behavioural model of the scheduling rules.
module tb_pump_duty_scheduler;

   logic       clk = 1'b0;
   logic       rst_n, tick, level_low, level_mid, level_high;
   logic [1:0] fault;
   logic       pump1, pump2, lead_pump, alarm;
   logic [1:0] state;
   logic [5:0] dut_vec;

   pump_duty_scheduler dut (
      .CLK100MHZ (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .level_low (level_low),
      .level_mid (level_mid),
      .level_high(level_high),
      .fault     (fault),
      .pump1     (pump1),
      .pump2     (pump2),
      .lead_pump (lead_pump),
      .state     (state),
      .alarm     (alarm)
   );

   always #5 clk = ~clk;

   // Observed vector: {pump1, pump2, lead_pump, state[1:0], alarm}
   assign dut_vec = {pump1, pump2, lead_pump, state, alarm};

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model: modes, lead index and counters as plain integers.
   localparam int MIdle = 0, MLead = 1, MBoth = 2, MCool = 3, CMax = 255;
   int m_mode, m_lead, m_dem, m_on, m_stag, m_off, m_alarm;

   function automatic int sat(input int v);
      return (v > CMax) ? CMax : v;
   endfunction

   task automatic model_reset();
      m_mode = MIdle; m_lead = 0; m_dem = 0; m_on = 0; m_stag = 0; m_off = 0; m_alarm = 0;
   endtask

   task automatic model_edge();
      int dem, t, nbad;
      logic [1:0] ok;
      dem  = level_high ? 0 : level_low ? 2 : level_mid ? 1 : m_dem;
      t    = int'(tick);
      ok   = ~fault;
      nbad = int'(fault[0]) + int'(fault[1]);
      m_alarm = (dem > 0 && nbad == 2) ? 1 : 0;
      m_dem = dem;
      case (m_mode)
         MIdle: if (dem > 0 && nbad < 2) begin
            if (!ok[m_lead]) m_lead = 1 - m_lead;
            m_mode = MLead; m_on = 0; m_stag = 0;
         end
         MLead: begin
            if (!ok[m_lead]) begin
               if (ok[1 - m_lead]) begin m_lead = 1 - m_lead; m_on = 0; m_stag = 0; end
               else begin m_mode = MCool; m_off = 0; end
            end else if (dem == 2 && m_stag >= 2 && ok[1 - m_lead]) begin
               m_mode = MBoth; m_on = sat(m_on + t);
            end else if (dem == 0 && m_on >= 8) begin
               m_mode = MCool; m_lead = 1 - m_lead; m_off = 0;
            end else begin
               m_on = sat(m_on + t);
               m_stag = (dem == 2) ? sat(m_stag + t) : 0;
            end
         end
         MBoth: begin
            if (nbad == 2) begin m_mode = MCool; m_off = 0; end
            else if (nbad == 1) begin
               m_lead = ok[0] ? 0 : 1; m_mode = MLead; m_on = sat(m_on + t); m_stag = 0;
            end else if (dem == 0 && m_on >= 8) begin
               m_mode = MCool; m_lead = 1 - m_lead; m_off = 0;
            end else if (dem < 2) begin
               m_mode = MLead; m_on = sat(m_on + t); m_stag = 0;
            end else m_on = sat(m_on + t);
         end
         default: begin
            if (m_off >= 4) m_mode = MIdle;
            else m_off = sat(m_off + t);
         end
      endcase
   endtask

   function automatic logic [5:0] model_out();
      logic p1, p2;
      p1 = (m_mode == MBoth) || (m_mode == MLead && m_lead == 0);
      p2 = (m_mode == MBoth) || (m_mode == MLead && m_lead == 1);
      return {p1, p2, m_lead[0], m_mode[1:0], m_alarm[0]};
   endfunction

   task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got {p1,p2,lead,state,alarm}=%b required %b at %0t",
                  name, got, exp, $time);
      end
   endtask

   task automatic clock1();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic lo, mi, hi, input logic [1:0] f, input logic tk);
      level_low = lo; level_mid = mi; level_high = hi; fault = f; tick = tk;
   endtask

   typedef struct {
      logic       lo, mi, hi;
      logic [1:0] f;
      logic       tk;
      int         n;
      logic [5:0] exp;
   } vec_t;

   function automatic vec_t mk(input logic lo, mi, hi, input logic [1:0] f, input logic tk,
                               input int n, input logic [5:0] exp);
      vec_t v;
      v.lo = lo; v.mi = mi; v.hi = hi; v.f = f; v.tk = tk; v.n = n; v.exp = exp;
      return v;
   endfunction

   vec_t tbl[$];

   initial begin
      tbl.push_back(mk(0, 1, 0, 2'b00, 0, 1, 6'b1_0_0_01_0));
      tbl.push_back(mk(0, 1, 0, 2'b00, 1, 3, 6'b1_0_0_01_0));
      tbl.push_back(mk(0, 0, 1, 2'b00, 1, 5, 6'b1_0_0_01_0));  // held by min-on
      tbl.push_back(mk(0, 0, 1, 2'b00, 0, 1, 6'b0_0_1_11_0));
      tbl.push_back(mk(1, 0, 0, 2'b00, 1, 3, 6'b0_0_1_11_0));
      tbl.push_back(mk(1, 0, 0, 2'b00, 1, 1, 6'b0_0_1_11_0));
      tbl.push_back(mk(1, 0, 0, 2'b00, 0, 1, 6'b0_0_1_00_0));
      tbl.push_back(mk(1, 0, 0, 2'b00, 0, 1, 6'b0_1_1_01_0));
      tbl.push_back(mk(1, 0, 0, 2'b00, 1, 2, 6'b0_1_1_01_0));
      tbl.push_back(mk(1, 0, 0, 2'b00, 0, 1, 6'b1_1_1_10_0));
      tbl.push_back(mk(0, 0, 0, 2'b00, 1, 2, 6'b1_1_1_10_0));  // demand held
      tbl.push_back(mk(1, 0, 0, 2'b10, 0, 1, 6'b1_0_0_01_0));
      tbl.push_back(mk(1, 0, 0, 2'b10, 1, 2, 6'b1_0_0_01_0));
      tbl.push_back(mk(1, 0, 0, 2'b10, 0, 1, 6'b1_0_0_01_0));  // lag faulted, no stagger
      tbl.push_back(mk(1, 0, 0, 2'b11, 0, 1, 6'b0_0_0_11_1));
      tbl.push_back(mk(0, 0, 1, 2'b11, 1, 4, 6'b0_0_0_11_0));
      tbl.push_back(mk(0, 1, 0, 2'b11, 0, 1, 6'b0_0_0_00_1));
      tbl.push_back(mk(0, 1, 0, 2'b11, 0, 2, 6'b0_0_0_00_1));
      tbl.push_back(mk(0, 1, 0, 2'b01, 0, 1, 6'b0_1_1_01_0));
      tbl.push_back(mk(0, 1, 0, 2'b00, 1, 2, 6'b0_1_1_01_0));
      tbl.push_back(mk(0, 1, 0, 2'b10, 0, 1, 6'b1_0_0_01_0));
      tbl.push_back(mk(0, 0, 1, 2'b10, 1, 7, 6'b1_0_0_01_0));
      tbl.push_back(mk(0, 0, 1, 2'b10, 1, 1, 6'b1_0_0_01_0));
      tbl.push_back(mk(0, 0, 1, 2'b10, 0, 1, 6'b0_0_1_11_0));
      tbl.push_back(mk(1, 0, 0, 2'b00, 1, 4, 6'b0_0_1_11_0));
      tbl.push_back(mk(1, 0, 0, 2'b00, 1, 1, 6'b0_0_1_00_0));
      tbl.push_back(mk(1, 0, 0, 2'b00, 1, 1, 6'b0_1_1_01_0));
      tbl.push_back(mk(1, 0, 0, 2'b00, 1, 2, 6'b0_1_1_01_0));
      tbl.push_back(mk(1, 0, 0, 2'b00, 1, 1, 6'b1_1_1_10_0));
      tbl.push_back(mk(0, 1, 0, 2'b00, 0, 1, 6'b0_1_1_01_0));
      tbl.push_back(mk(1, 0, 0, 2'b00, 1, 3, 6'b1_1_1_10_0));
      tbl.push_back(mk(0, 0, 1, 2'b00, 0, 1, 6'b0_1_1_01_0));  // min-on not met
      tbl.push_back(mk(0, 0, 1, 2'b00, 1, 2, 6'b0_1_1_01_0));
      tbl.push_back(mk(0, 0, 1, 2'b00, 0, 1, 6'b0_0_0_11_0));

      rst_n = 1'b0;
      set_in(0, 0, 0, 2'b00, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         set_in(tbl[i].lo, tbl[i].mi, tbl[i].hi, tbl[i].f, tbl[i].tk);
         repeat (tbl[i].n) clock1();
         check($sformatf("table[%0d]", i), dut_vec, tbl[i].exp);
      end

      // Reset held with demand present, then stagger with a tick every 4 clocks.
      rst_n = 1'b0;
      set_in(1, 0, 0, 2'b00, 0);
      repeat (2) @(posedge clk);
      #1;
      check("reset_hold", dut_vec, 6'b0);
      rst_n = 1'b1;
      model_reset();
      clock1();
      check("lead_after_release", dut_vec, 6'b1_0_0_01_0);
      for (int k = 1; k <= 10; k++) begin
         tick = (k % 4 == 0);
         clock1();
         check($sformatf("stagger_clk%0d", k), dut_vec,
               (k >= 9) ? 6'b1_1_0_10_0 : 6'b1_0_0_01_0);
      end

      // Asynchronous reset pulse between edges while both pumps run.
      #2 rst_n = 1'b0;
      #1;
      check("async_reset", dut_vec, 6'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();

      // Failover out of BOTH, then double fault.
      set_in(1, 0, 0, 2'b00, 1);
      repeat (4) clock1();
      check("both_again", dut_vec, 6'b1_1_0_10_0);
      fault = 2'b01;
      clock1();
      check("both_fault_p1", dut_vec, 6'b0_1_1_01_0);
      fault = 2'b11;
      clock1();
      check("double_fault", dut_vec, 6'b0_0_1_11_1);

      // Randomized run against the model.
      rst_n = 1'b0;
      set_in(0, 0, 0, 2'b00, 0);
      #2 rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            level_low  = 1'($urandom_range(0, 1));
            level_mid  = 1'($urandom_range(0, 1));
            level_high = ($urandom_range(0, 2) == 0);
         end
         if ($urandom_range(0, 29) == 0)
            fault = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'($urandom_range(0, 3));
         tick = ($urandom_range(0, 2) == 0);
         clock1();
         check($sformatf("random[%0d]", i), dut_vec, model_out());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
